// File: rtl/lc3b_types.sv
// Shared LC-3b types: cache line, data-cache FSM state and line helpers.
package lc3b_types;

  localparam int OFFSET_W = 4;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } lc3b_dcache_state;

  function automatic lc3b_line merge_word(
    input lc3b_line   line,
    input logic [2:0] sel,
    input logic [15:0] wd,
    input logic [1:0] be
  );
    lc3b_line r;
    r = line;
    if (be[0]) r[{sel, 4'd0} +: 8] = wd[7:0];
    if (be[1]) r[{sel, 4'd8} +: 8] = wd[15:8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage array: one async read port, one write port, optional async clear.
module dcache_array #(
  parameter int W   = 1,
  parameter int D   = 8,
  parameter bit CLR = 1'b0,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];

  generate
    if (CLR) begin : g_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) mem_q[i] <= '0;
        end else if (we_i) begin
          mem_q[waddr_i] <= wdata_i;
        end
      end
    end else begin : g_noclr
      logic unused_rst;
      assign unused_rst = rst_n;
      always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
      end
    end
  endgenerate

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache for the LC-3b MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 16 - OFFSET_W - IW;

  lc3b_dcache_state state_q;
  logic         pread_q, pwrite_q;
  logic [15:0]  paddr_q;
  lc3b_line     pwdata_q;

  logic [IW-1:0] idx_req, idx_pm, waddr;
  logic [TW-1:0] tag_req, tag_pm, tag_rd;
  logic [2:0]    sel;
  logic          valid_rd, dirty_rd;
  lc3b_line      line_rd, line_wd;
  logic          req, hit, wr_hit, miss_go;
  logic          fill_done, wb_done, we_line, we_dirty;

  assign req     = mem_read | mem_write;
  assign sel     = mem_address[3:1];
  assign idx_req = mem_address[OFFSET_W+IW-1:OFFSET_W];
  assign tag_req = mem_address[15:OFFSET_W+IW];
  assign idx_pm  = paddr_q[OFFSET_W+IW-1:OFFSET_W];
  assign tag_pm  = paddr_q[15:OFFSET_W+IW];

  assign hit       = (state_q == IDLE) & req & valid_rd & (tag_rd == tag_req);
  assign wr_hit    = hit & mem_write;
  assign miss_go   = (state_q == IDLE) & req & ~hit;
  assign fill_done = (state_q == FILL) & pmem_resp;
  assign wb_done   = (state_q == WRITEBACK) & pmem_resp;

  assign we_line  = wr_hit | fill_done;
  assign we_dirty = wr_hit | fill_done | wb_done;
  assign waddr    = wr_hit ? idx_req : idx_pm;
  assign line_wd  = fill_done ? pmem_rdata
                  : merge_word(line_rd, sel, mem_wdata, mem_byte_enable);

  dcache_array #(.W(1), .D(NUM_SETS), .CLR(1'b1)) u_valid (
    .clk(clk), .rst_n(rst_n), .we_i(we_line), .waddr_i(waddr),
    .wdata_i(1'b1), .raddr_i(idx_req), .rdata_o(valid_rd)
  );

  // A finished write-back leaves memory current, so the line is clean.
  dcache_array #(.W(1), .D(NUM_SETS), .CLR(1'b1)) u_dirty (
    .clk(clk), .rst_n(rst_n), .we_i(we_dirty), .waddr_i(waddr),
    .wdata_i(wr_hit), .raddr_i(idx_req), .rdata_o(dirty_rd)
  );

  dcache_array #(.W(TW), .D(NUM_SETS), .CLR(1'b0)) u_tag (
    .clk(clk), .rst_n(rst_n), .we_i(fill_done), .waddr_i(idx_pm),
    .wdata_i(tag_pm), .raddr_i(idx_req), .rdata_o(tag_rd)
  );

  dcache_array #(.W(128), .D(NUM_SETS), .CLR(1'b0)) u_data (
    .clk(clk), .rst_n(rst_n), .we_i(we_line), .waddr_i(waddr),
    .wdata_i(line_wd), .raddr_i(idx_req), .rdata_o(line_rd)
  );

  assign mem_resp  = hit;
  assign mem_rdata = hit ? line_rd[{sel, 4'd0} +: 16] : 16'h0;

  assign pmem_read    = pread_q;
  assign pmem_write   = pwrite_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = pwdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_go) begin
            if (valid_rd && dirty_rd) begin
              state_q  <= WRITEBACK;
              pwrite_q <= 1'b1;
              paddr_q  <= {tag_rd, idx_req, 4'b0};
              pwdata_q <= line_rd;
            end else begin
              state_q <= FILL;
              pread_q <= 1'b1;
              paddr_q <= {tag_req, idx_req, 4'b0};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            // A flushed request skips the fill and goes straight home.
            if (req) begin
              state_q <= FILL;
              pread_q <= 1'b1;
              paddr_q <= {tag_req, idx_req, 4'b0};
            end else begin
              state_q <= IDLE;
              paddr_q <= '0;
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state_q <= IDLE;
            pread_q <= 1'b0;
            paddr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit && !(&hit_q)) hit_q <= hit_q + 16'd1;
      if (miss_go && !(&miss_q)) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Randomized self-checking bench for dcache against a set/tag cache model
// and a sparse line-addressed memory model.
module tb_dcache;

  localparam int NS = 8;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache #(.NUM_SETS(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  bit           m_valid [NS];
  bit           m_dirty [NS];
  int           m_tag   [NS];
  logic [127:0] m_line  [NS];
  logic [127:0] mem_m   [int];
  int           m_hits, m_misses;
  logic [15:0]  last_rd;

  function automatic logic [127:0] mem_get(input int la);
    logic [127:0] r;
    if (mem_m.exists(la)) return mem_m[la];
    for (int k = 0; k < 8; k++)
      r[k*16 +: 16] = 16'(la) ^ 16'(k * 16'h1357) ^ 16'h0f0f;
    return r;
  endfunction

  function automatic int idx_of(input int a);
    return (a >> 4) % NS;
  endfunction

  function automatic int tag_of(input int a);
    return a >> (4 + IW);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // Entered at a drive point (just after a rising edge); leaves at one.
  task automatic pmem_serve(input bit is_wr, input int exp_addr,
                            input logic [127:0] exp_data);
    int i;
    logic act;
    i = 0;
    @(negedge clk);
    act = is_wr ? pmem_write : pmem_read;
    while (!act && i < 8) begin
      @(negedge clk);
      act = is_wr ? pmem_write : pmem_read;
      i++;
    end
    chk(is_wr ? "wb_req" : "fill_req", act, 1'b1);
    if (!act) begin
      @(posedge clk); #1;
      return;
    end
    chk("pm_addr", pmem_address, 16'(exp_addr));
    chk("pm_excl", is_wr ? pmem_read : pmem_write, 1'b0);
    if (is_wr) chk("wb_data", pmem_wdata, exp_data);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("pm_hold", is_wr ? pmem_write : pmem_read, 1'b1);
    end
    pmem_resp = 1'b1;
    if (is_wr) mem_m[exp_addr] = pmem_wdata;
    else pmem_rdata = mem_get(exp_addr);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("pm_drop", is_wr ? pmem_write : pmem_read, 1'b0);
  endtask

  task automatic access(input int a, input bit rd, input bit wr,
                        input logic [15:0] wd, input logic [1:0] be);
    int idx, tg, sel;
    bit hit;
    logic [127:0] ln;
    idx = idx_of(a);
    tg  = tag_of(a);
    sel = (a >> 1) & 7;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    mem_address = 16'(a);
    mem_read = rd;
    mem_write = wr;
    mem_wdata = wd;
    mem_byte_enable = be;
    if (!hit) begin
      @(negedge clk);
      chk("miss_noresp", mem_resp, 1'b0);
      m_misses++;
      if (m_valid[idx] && m_dirty[idx])
        pmem_serve(1, (m_tag[idx] << (4 + IW)) | (idx << 4), m_line[idx]);
      pmem_serve(0, a & 16'hfff0, 128'h0);
      m_line[idx]  = mem_get(a & 16'hfff0);
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
    end
    @(negedge clk);
    chk("resp", mem_resp, 1'b1);
    chk("hit_nopm", pmem_read | pmem_write, 1'b0);
    m_hits++;
    last_rd = mem_rdata;
    if (!wr) begin
      chk("rdata", mem_rdata, m_line[idx][sel*16 +: 16]);
    end else begin
      ln = m_line[idx];
      if (be[0]) ln[sel*16 +: 8] = wd[7:0];
      if (be[1]) ln[sel*16 + 8 +: 8] = wd[15:8];
      m_line[idx]  = ln;
      m_dirty[idx] = 1;
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 16'(m_hits));
    chk("miss_count", miss_count, 16'(m_misses));
`endif
  endtask

  initial begin
    int a, i;
    rst_n = 1'b0;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    mem_byte_enable = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    model_clear();
    #1;
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_rdata", mem_rdata, 16'h0);
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_pwrite", pmem_write, 1'b0);
    chk("rst_paddr", pmem_address, 16'h0);
    chk("rst_pwdata", pmem_wdata, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    mem_m[16'h0040] = {16'h8888, 16'h7777, 16'h6666, 16'h5555,
                       16'h4444, 16'h3333, 16'h2222, 16'h1111};
    access(16'h0040, 1, 0, 16'h0, 2'b11);
    chk("tp_rd40", last_rd, 16'h1111);
    access(16'h0042, 1, 0, 16'h0, 2'b11);
    chk("tp_rd42", last_rd, 16'h2222);
    access(16'h0045, 0, 1, 16'hAB00, 2'b10);
    access(16'h0044, 1, 0, 16'h0, 2'b11);
    chk("tp_rd44", last_rd, 16'hAB33);
    access(16'h00C0, 1, 0, 16'h0, 2'b11);
    chk("tp_wb_mem", mem_m[16'h0040][47:32], 16'hAB33);
    check_stats();
    access(16'h0040, 1, 0, 16'h0, 2'b11);
    chk("tp_rd40_again", last_rd, 16'h1111);
    access(16'h0046, 1, 1, 16'h5AA5, 2'b11);
    access(16'h0046, 1, 0, 16'h0, 2'b11);
    chk("tp_rw_as_wr", last_rd, 16'h5AA5);
    access(16'h0048, 0, 1, 16'hFFFF, 2'b00);
    access(16'h0048, 1, 0, 16'h0, 2'b11);
    chk("tp_be00", last_rd, 16'h5555);
    check_stats();

    // Reset during FILL.
    mem_address = 16'h0150;
    mem_read = 1'b1;
    i = 0;
    @(negedge clk);
    while (!pmem_read && i < 8) begin
      @(negedge clk);
      i++;
    end
    chk("rst_fill_req", pmem_read, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fill_drop", pmem_read, 1'b0);
    chk("rst_fill_paddr", pmem_address, 16'h0);
    model_clear();
    mem_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_stats();

    // Flush mid-FILL: the fill lands but no response is given.
    mem_address = 16'h0262;
    mem_read = 1'b1;
    i = 0;
    @(negedge clk);
    while (!pmem_read && i < 8) begin
      @(negedge clk);
      i++;
    end
    chk("flush_req", pmem_read, 1'b1);
    m_misses++;
    mem_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = mem_get(16'h0260);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("flush_drop", pmem_read, 1'b0);
    @(negedge clk);
    chk("flush_noresp", mem_resp, 1'b0);
    chk("flush_idle", pmem_address, 16'h0);
    m_line[6]  = mem_get(16'h0260);
    m_valid[6] = 1;
    m_dirty[6] = 0;
    m_tag[6]   = tag_of(16'h0260);
    @(posedge clk); #1;
    access(16'h0262, 1, 0, 16'h0, 2'b11);
    access(16'h0150, 1, 0, 16'h0, 2'b11);
    check_stats();

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0, 1: access(a, 1, 0, 16'h0, 2'($urandom_range(0, 3)));
        2: access(a, 0, 1, 16'($urandom), 2'($urandom_range(0, 3)));
        default: access(a, 1, 1, 16'($urandom), 2'($urandom_range(0, 3)));
      endcase
    end
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
